threshold_engine: RTL and testbench

THRESHOLD_ENGINE -- requirements
Module: threshold_engine

---
 rtl/threshold_pkg.sv | 18 +
 rtl/threshold_engine_if.sv | 31 +++
 rtl/threshold_compare.sv | 39 +++
 rtl/threshold_engine.sv | 185 ++++++++++++++++++
 tb/tb_threshold_engine.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/threshold_pkg.sv
// rtl/threshold_pkg.sv - mode encodings and FSM state type for the threshold engine
package threshold_pkg;

    typedef enum logic [1:0] {
        MODE_LOCAL     = 2'd0,
        MODE_LOCAL_INV = 2'd1,
        MODE_GLOBAL    = 2'd2,
        MODE_RESERVED  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/threshold_engine_if.sv
// rtl/threshold_engine_if.sv - source memory read and result write bundle
interface threshold_engine_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int PIXEL_BITS  = 8
);
    logic [WIDTH_BITS-1:0]  img_col;
    logic [HEIGHT_BITS-1:0] img_row;
    logic [PIXEL_BITS-1:0]  img_data;
    logic [WIDTH_BITS-1:0]  thr_col;
    logic [HEIGHT_BITS-1:0] thr_row;
    logic [PIXEL_BITS-1:0]  thr_data;
    logic [WIDTH_BITS-1:0]  res_col;
    logic [HEIGHT_BITS-1:0] res_row;
    logic                   res_data;
    logic                   res_wren;

    // Engine side: issues read addresses, consumes samples, writes results.
    modport master (
        output img_col, img_row, thr_col, thr_row,
        output res_col, res_row, res_data, res_wren,
        input  img_data, thr_data
    );

    // Memory side: returns samples, accepts result writes.
    modport slave (
        input  img_col, img_row, thr_col, thr_row,
        input  res_col, res_row, res_data, res_wren,
        output img_data, thr_data
    );
endinterface

// File: rtl/threshold_compare.sv
// rtl/threshold_compare.sv - saturating threshold-minus-offset and pixel compare
module threshold_compare #(
    parameter int PIXEL_BITS  = 8,
    parameter int OFFSET_BITS = 8
) (
    input  logic [PIXEL_BITS-1:0]         pixel_i,
    input  logic [PIXEL_BITS-1:0]         threshold_i,
    input  logic signed [OFFSET_BITS-1:0] offset_i,
    input  logic                          invert_i,
    output logic                          result_o
);
    // Two guard bits keep T - offset from wrapping; offset is assumed to fit
    // in PIXEL_BITS+2 bits after sign extension.
    localparam int EW = PIXEL_BITS + 2;
    localparam logic signed [EW-1:0] MAX_EFF = {2'b00, {PIXEL_BITS{1'b1}}};

    logic signed [EW-1:0]  thr_ext;
    logic signed [EW-1:0]  off_ext;
    logic signed [EW-1:0]  diff;
    logic [PIXEL_BITS-1:0] eff;
    logic                  above;

    // Clamp the effective threshold to the pixel range, then compare.
    always_comb begin
        thr_ext = $signed({2'b00, threshold_i});
        off_ext = EW'(offset_i);
        diff    = thr_ext - off_ext;
        if (diff < 0) begin
            eff = '0;
        end else if (diff > MAX_EFF) begin
            eff = '1;
        end else begin
            eff = diff[PIXEL_BITS-1:0];
        end
        above    = (pixel_i > eff);
        result_o = invert_i ? ~above : above;
    end

endmodule

// File: rtl/threshold_engine.sv
// rtl/threshold_engine.sv - raster-scan image binarizer; THRESHOLD_WHITE_COUNT_EN adds oWhiteCount
module threshold_engine
    import threshold_pkg::*;
#(
    parameter int WIDTH_BITS   = 8,
    parameter int HEIGHT_BITS  = 8,
    parameter int PIXEL_BITS   = 8,
    parameter int OFFSET_BITS  = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iStart,
    input  logic [1:0]                    iMode,
    input  logic signed [OFFSET_BITS-1:0] iOffset,
    input  logic [PIXEL_BITS-1:0]         iGlobalThreshold,
    output logic [WIDTH_BITS-1:0]         oImageCol,
    output logic [HEIGHT_BITS-1:0]        oImageRow,
    input  logic [PIXEL_BITS-1:0]         iImageData,
    output logic [WIDTH_BITS-1:0]         oThresholdCol,
    output logic [HEIGHT_BITS-1:0]        oThresholdRow,
    input  logic [PIXEL_BITS-1:0]         iThresholdData,
    output logic [WIDTH_BITS-1:0]         oResultCol,
    output logic [HEIGHT_BITS-1:0]        oResultRow,
    output logic                          oResultData,
    output logic                          oResultWren,
    output logic                          oBusy,
    output logic                          oDone
`ifdef THRESHOLD_WHITE_COUNT_EN
    ,
    output logic [WIDTH_BITS+HEIGHT_BITS:0] oWhiteCount
`endif
);
    localparam int AW = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_e                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     start_accept;
    mode_e                    mode_q;
    logic signed [OFFSET_BITS-1:0] offset_q;
    logic [PIXEL_BITS-1:0]    gthr_q;
    logic [READ_LATENCY-1:0]  pipe_v_q;
    logic [AW-1:0]            pipe_a_q [READ_LATENCY];
    logic                     res_wren_q;
    logic                     res_data_q;
    logic [AW-1:0]            res_addr_q;
    logic [PIXEL_BITS-1:0]    thr_sel;
    logic                     invert;
    logic                     cmp_result;

    // Next-state and address-counter logic; iStart only matters in IDLE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    start_accept = 1'b1;
                    addr_d       = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_v_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and address counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Frame configuration is captured once per accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q   <= MODE_LOCAL;
            offset_q <= '0;
            gthr_q   <= '0;
        end else if (start_accept) begin
            mode_q   <= mode_e'(iMode);
            offset_q <= iOffset;
            gthr_q   <= iGlobalThreshold;
        end
    end

    // Valid/address pipeline that lines each address up with its read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q[0] <= (state_q == ST_RUN);
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
            end
        end
        pipe_a_q[0] <= addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_a_q[i] <= pipe_a_q[i-1];
        end
    end

    // GLOBAL ignores the threshold memory; reserved mode behaves as LOCAL.
    always_comb begin
        thr_sel = (mode_q == MODE_GLOBAL) ? gthr_q : iThresholdData;
        invert  = (mode_q == MODE_LOCAL_INV);
    end

    threshold_compare #(
        .PIXEL_BITS  (PIXEL_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_compare (
        .pixel_i     (iImageData),
        .threshold_i (thr_sel),
        .offset_i    (offset_q),
        .invert_i    (invert),
        .result_o    (cmp_result)
    );

    // Registered result write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_wren_q <= 1'b0;
            res_data_q <= 1'b0;
            res_addr_q <= '0;
        end else begin
            res_wren_q <= pipe_v_q[READ_LATENCY-1];
            if (pipe_v_q[READ_LATENCY-1]) begin
                res_data_q <= cmp_result;
                res_addr_q <= pipe_a_q[READ_LATENCY-1];
            end
        end
    end

`ifdef THRESHOLD_WHITE_COUNT_EN
    logic [AW:0] white_q;

    // White-pixel tally: cleared on start, held after the frame completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            white_q <= '0;
        end else if (start_accept) begin
            white_q <= '0;
        end else if (res_wren_q && res_data_q) begin
            white_q <= white_q + 1'b1;
        end
    end

    assign oWhiteCount = white_q;
`endif

    assign oImageCol     = addr_q[WIDTH_BITS-1:0];
    assign oImageRow     = addr_q[AW-1:WIDTH_BITS];
    assign oThresholdCol = addr_q[WIDTH_BITS-1:0];
    assign oThresholdRow = addr_q[AW-1:WIDTH_BITS];
    assign oResultCol    = res_addr_q[WIDTH_BITS-1:0];
    assign oResultRow    = res_addr_q[AW-1:WIDTH_BITS];
    assign oResultData   = res_data_q;
    assign oResultWren   = res_wren_q;
    assign oBusy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign oDone         = (state_q == ST_DONE);

endmodule

// File: tb/tb_threshold_engine.sv
// tb/tb_threshold_engine.sv - directed self-checking bench for threshold_engine (4x4, latency 3)
module tb_threshold_engine;
    import threshold_pkg::*;

    localparam int W = 2;
    localparam int H = 2;
    localparam int P = 8;
    localparam int O = 8;
    localparam int L = 3;
    localparam int N = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iStart = 1'b0;
    logic [1:0] iMode = 2'd0;
    logic [7:0] iOffset = 8'd0;
    logic [7:0] iGlobalThreshold = 8'd0;
    logic       oBusy;
    logic       oDone;
`ifdef THRESHOLD_WHITE_COUNT_EN
    logic [4:0] oWhiteCount;
`endif

    threshold_engine_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .PIXEL_BITS(P)) mem_if ();

    threshold_engine #(
        .WIDTH_BITS(W), .HEIGHT_BITS(H), .PIXEL_BITS(P), .OFFSET_BITS(O), .READ_LATENCY(L)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .iStart           (iStart),
        .iMode            (iMode),
        .iOffset          (iOffset),
        .iGlobalThreshold (iGlobalThreshold),
        .oImageCol        (mem_if.img_col),
        .oImageRow        (mem_if.img_row),
        .iImageData       (mem_if.img_data),
        .oThresholdCol    (mem_if.thr_col),
        .oThresholdRow    (mem_if.thr_row),
        .iThresholdData   (mem_if.thr_data),
        .oResultCol       (mem_if.res_col),
        .oResultRow       (mem_if.res_row),
        .oResultData      (mem_if.res_data),
        .oResultWren      (mem_if.res_wren),
        .oBusy            (oBusy),
        .oDone            (oDone)
`ifdef THRESHOLD_WHITE_COUNT_EN
        ,
        .oWhiteCount      (oWhiteCount)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Source memories with an L-cycle read pipeline.
    logic [7:0] img_mem [N];
    logic [7:0] thr_mem [N];
    logic [7:0] img_pipe [L];
    logic [7:0] thr_pipe [L];
    always @(posedge clock) begin
        img_pipe[0] <= img_mem[{mem_if.img_row, mem_if.img_col}];
        thr_pipe[0] <= thr_mem[{mem_if.thr_row, mem_if.thr_col}];
        for (int i = 1; i < L; i++) begin
            img_pipe[i] <= img_pipe[i-1];
            thr_pipe[i] <= thr_pipe[i-1];
        end
    end
    assign mem_if.img_data = img_pipe[L-1];
    assign mem_if.thr_data = thr_pipe[L-1];

    // Result-port monitor, per frame and cumulative.
    int         frame_wr = 0, total_wr = 0, total_done = 0;
    int         start_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    logic [15:0] res_bits = 16'h0;
    bit         order_err = 1'b0;
    logic [3:0] waddr;
    always @(negedge clock) begin
        if (iStart && !oBusy && !oDone && !reset) begin
            frame_wr  = 0;
            res_bits  = 16'h0;
            order_err = 1'b0;
            start_cyc = cyc;
        end
        if (mem_if.res_wren) begin
            waddr = {mem_if.res_row, mem_if.res_col};
            if (int'(waddr) != frame_wr) order_err = 1'b1;
            if (frame_wr == 0) first_wr_cyc = cyc;
            res_bits[waddr] = mem_if.res_data;
            frame_wr++;
            total_wr++;
            last_wr_cyc = cyc;
        end
        if (oDone) begin
            done_cyc = cyc;
            total_done++;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] ramp_local;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input logic [7:0] step, input logic [7:0] thr);
        for (int i = 0; i < N; i++) begin
            img_mem[i] = 8'(base + 8'(i) * step);
            thr_mem[i] = thr;
        end
    endtask

    task automatic wait_done;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (oDone === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: oDone not seen within 200 cycles, required a pulse");
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic [7:0] off,
                             input logic [7:0] gthr, input bit hold);
        tick;
        iMode = mode;
        iOffset = off;
        iGlobalThreshold = gthr;
        iStart = 1'b1;
        tick;
        if (!hold) iStart = 1'b0;
        wait_done;
    endtask

    task automatic test_reset;
        fill(8'd0, 8'd16, 8'd128);
        reset = 1'b1;
        repeat (3) tick;
        @(negedge clock);
        checks++;
        if ({oBusy, oDone, mem_if.res_wren, mem_if.res_data} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: busy/done/wren/data=%b required 0000",
                     {oBusy, oDone, mem_if.res_wren, mem_if.res_data});
        end
        checks++;
        if ({mem_if.img_row, mem_if.img_col} !== 4'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d required 0", {mem_if.img_row, mem_if.img_col});
        end
`ifdef THRESHOLD_WHITE_COUNT_EN
        checks++;
        if (oWhiteCount !== 5'd0) begin
            errors++;
            $display("FAIL reset_white: got %0d required 0", oWhiteCount);
        end
`endif
        tick;
        reset = 1'b0;
        iMode = 2'd0;
        iOffset = 8'd0;
        iStart = 1'b1;
        tick;
        iStart = 1'b0;
        @(negedge clock);
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("FAIL first_start: oBusy=%b required 1", oBusy);
        end
        wait_done;
    endtask

    task automatic test_local_offset;
        fill(8'd0, 8'd0, 8'd0);
        img_mem[0] = 8'd100; thr_mem[0] = 8'd101;
        img_mem[1] = 8'd99;  thr_mem[1] = 8'd101;
        run_frame(2'd0, 8'd2, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'h0001) begin
            errors++;
            $display("FAIL local_offset: got %h required 0001", res_bits);
        end
    endtask

    task automatic test_saturation;
        fill(8'd0, 8'd0, 8'd0);
        img_mem[0] = 8'd0; thr_mem[0] = 8'd1;
        img_mem[1] = 8'd1; thr_mem[1] = 8'd1;
        run_frame(2'd0, 8'd5, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'h0002) begin
            errors++;
            $display("FAIL sat_low: got %h required 0002", res_bits);
        end
        fill(8'd0, 8'd0, 8'd0);
        img_mem[0] = 8'd255; thr_mem[0] = 8'd250;
        img_mem[1] = 8'd254; thr_mem[1] = 8'd240;
        img_mem[2] = 8'd11;  thr_mem[2] = 8'd0;
        run_frame(2'd0, 8'hF6, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'h0006) begin
            errors++;
            $display("FAIL sat_high: got %h required 0006", res_bits);
        end
    endtask

    task automatic test_ramp;
        fill(8'd0, 8'd16, 8'd128);
        run_frame(2'd0, 8'd0, 8'd0, 1'b0);
        ramp_local = res_bits;
        checks++;
        if (res_bits !== 16'hFE00) begin
            errors++;
            $display("FAIL ramp_data: got %h required fe00", res_bits);
        end
        checks++;
        if (frame_wr !== 16 || order_err) begin
            errors++;
            $display("FAIL ramp_writes: got %0d writes order_err=%0d required 16 in order", frame_wr, order_err);
        end
        checks++;
        if (first_wr_cyc - start_cyc !== L + 2) begin
            errors++;
            $display("FAIL ramp_latency: got %0d required %0d", first_wr_cyc - start_cyc, L + 2);
        end
        checks++;
        if (done_cyc - last_wr_cyc !== 1) begin
            errors++;
            $display("FAIL ramp_done_gap: got %0d required 1", done_cyc - last_wr_cyc);
        end
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b required 0", oBusy);
        end
        @(negedge clock);
        checks++;
        if ({oBusy, oDone} !== 2'b00) begin
            errors++;
            $display("FAIL after_done: busy/done=%b required 00", {oBusy, oDone});
        end
    endtask

    task automatic test_modes;
        fill(8'd0, 8'd16, 8'd128);
        run_frame(2'd1, 8'd0, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'h01FF || res_bits !== ~ramp_local) begin
            errors++;
            $display("FAIL local_inv: got %h required 01ff", res_bits);
        end
        run_frame(2'd3, 8'd0, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'hFE00) begin
            errors++;
            $display("FAIL reserved_mode: got %h required fe00", res_bits);
        end
        fill(8'd118, 8'd1, 8'd255);
        img_mem[15] = 8'd255;
        run_frame(2'd2, 8'd0, 8'd128, 1'b0);
        checks++;
        if (res_bits !== 16'hF800) begin
            errors++;
            $display("FAIL global: got %h required f800", res_bits);
        end
    endtask

    task automatic test_reset_midframe;
        bit found;
        bit bad;
        int snap;
        fill(8'd0, 8'd16, 8'd128);
        tick;
        iMode = 2'd0;
        iOffset = 8'd0;
        iStart = 1'b1;
        tick;
        iStart = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (oBusy && {mem_if.img_row, mem_if.img_col} == 4'd5) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midframe_addr5: address 5 not seen, required it within 40 cycles");
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        snap = total_wr;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({oBusy, oDone, mem_if.res_wren, mem_if.res_data} !== 4'b0000 ||
            {mem_if.img_row, mem_if.img_col} !== 4'd0) begin
            errors++;
            $display("FAIL midframe_outputs: busy/done/wren/data=%b addr=%0d required 0000 addr 0",
                     {oBusy, oDone, mem_if.res_wren, mem_if.res_data}, {mem_if.img_row, mem_if.img_col});
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_if.res_wren !== 1'b0 || oBusy !== 1'b0) bad = 1'b1;
        end
        #1;
        checks++;
        if (bad || total_wr !== snap) begin
            errors++;
            $display("FAIL midframe_quiet: %0d writes after reset, required 0", total_wr - snap);
        end
        run_frame(2'd0, 8'd0, 8'd0, 1'b0);
        checks++;
        if (res_bits !== 16'hFE00 || frame_wr !== 16 || order_err) begin
            errors++;
            $display("FAIL midframe_restart: got %h with %0d writes required fe00 with 16", res_bits, frame_wr);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        bit bad;
        fill(8'd0, 8'd16, 8'd128);
        run_frame(2'd0, 8'd0, 8'd0, 1'b1);
        d0 = total_done;
        checks++;
        if (frame_wr !== 16 || res_bits !== 16'hFE00) begin
            errors++;
            $display("FAIL held_first: got %0d writes %h required 16 fe00", frame_wr, res_bits);
        end
        @(negedge clock);
        checks++;
        if ({oBusy, oDone} !== 2'b00) begin
            errors++;
            $display("FAIL held_idle: busy/done=%b required 00", {oBusy, oDone});
        end
        @(negedge clock);
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: oBusy=%b required 1", oBusy);
        end
        tick;
        iStart = 1'b0;
        wait_done;
        checks++;
        if (frame_wr !== 16 || res_bits !== 16'hFE00 || order_err) begin
            errors++;
            $display("FAIL held_second: got %0d writes %h required 16 fe00", frame_wr, res_bits);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (oBusy !== 1'b0) bad = 1'b1;
        end
        #1;
        checks++;
        if (bad || total_done !== d0 + 1) begin
            errors++;
            $display("FAIL held_extra: %0d extra frames required exactly 1", total_done - d0);
        end
    endtask

`ifdef THRESHOLD_WHITE_COUNT_EN
    task automatic test_white_count;
        fill(8'd200, 8'd0, 8'd100);
        run_frame(2'd0, 8'd0, 8'd0, 1'b0);
        checks++;
        if (oWhiteCount !== 5'd16) begin
            errors++;
            $display("FAIL white_done: got %0d required 16", oWhiteCount);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (oWhiteCount !== 5'd16) begin
            errors++;
            $display("FAIL white_hold: got %0d required 16", oWhiteCount);
        end
        fill(8'd0, 8'd16, 8'd128);
        run_frame(2'd0, 8'd0, 8'd0, 1'b0);
        checks++;
        if (oWhiteCount !== 5'd7) begin
            errors++;
            $display("FAIL white_ramp: got %0d required 7", oWhiteCount);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_local_offset;
        test_saturation;
        test_ramp;
        test_modes;
        test_reset_midframe;
        test_back_to_back;
`ifdef THRESHOLD_WHITE_COUNT_EN
        test_white_count;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
